// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder
//  Purpose  : Input-side sequencer for a 4x4 weight-stationary systolic array.
//             Captures a 4x4 weight tile and pulses a one-cycle load strobe.
//             It then accepts activation vectors over valid/ready and drives
//             them diagonally skewed onto the array's four west-edge rows.
//             Row r lags row 0 by r cycles. After the last vector it drains
//             zeros until the skew pipeline is empty, then pulses done.
//  Ports    : clk, reset (async, active-high)
//             w_valid/w_ready/w_data  - weight tile handshake, [row][col]
//             weights, load           - registered tile and load strobe
//             in_valid/in_ready/in_vec/in_last - activation stream
//             row1_val..row4_val      - skewed west-edge array inputs
//             busy, done, vec_count   - status
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [3:0][3:0][WIDTH-1:0]  w_data,
  output logic [3:0][3:0][WIDTH-1:0]  weights,
  output logic                        load,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0][WIDTH-1:0]       in_vec,
  input  logic                        in_last,
  output logic [WIDTH-1:0]            row1_val,
  output logic [WIDTH-1:0]            row2_val,
  output logic [WIDTH-1:0]            row3_val,
  output logic [WIDTH-1:0]            row4_val,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 vec_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [3:0][3:0][WIDTH-1:0]   weights_q, weights_d;
  logic [15:0]                  vec_count_q, vec_count_d;
  logic [1:0]                   drain_cnt_q, drain_cnt_d;

  logic                         in_hs;
  logic [3:0][WIDTH-1:0]        push_vec;
  logic [3:0][WIDTH-1:0]        row_val;

  // --------------------------------------------------------------------------
  // Control: next state and Moore-style outputs. All handshake outputs are
  // decoded from the state register so that asynchronous reset drives them to
  // their reset values immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    weights_d   = weights_q;
    vec_count_d = vec_count_q;
    drain_cnt_d = drain_cnt_q;
    w_ready     = 1'b0;
    in_ready    = 1'b0;
    load        = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    in_hs       = 1'b0;

    case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        busy    = 1'b0;
        if (w_valid) begin
          weights_d   = w_data;
          vec_count_d = 16'd0;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        load    = 1'b1;
        state_d = STREAM;
      end

      STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_hs = 1'b1;
          if (vec_count_q != 16'hFFFF) begin
            vec_count_d = vec_count_q + 16'd1;
          end
          // in_last only matters on an accepted vector
          if (in_last) begin
            drain_cnt_d = 2'd3;
            state_d     = DRAIN;
          end
        end
      end

      DRAIN: begin
        drain_cnt_d = drain_cnt_q - 2'd1;
        // three drain cycles flush the deepest (row 4) skew chain
        if (drain_cnt_q == 2'd1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bubbles, drain and idle cycles all feed zeros: a zero activation leaves
  // the array's partial sums untouched.
  always_comb begin
    push_vec = '0;
    if (in_hs) begin
      push_vec = in_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      weights_q   <= '0;
      vec_count_q <= 16'd0;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      weights_q   <= weights_d;
      vec_count_q <= vec_count_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Skew pipeline: row r is a chain of r+1 registers, so element r of a vector
  // pushed at cycle t appears on the row output at cycle t+1+r. The chains
  // shift every cycle regardless of state.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [r:0][WIDTH-1:0] pipe_q;
    logic [r:0][WIDTH-1:0] pipe_d;

    if (r == 0) begin : g_first
      always_comb begin
        pipe_d = push_vec[r];
      end
    end else begin : g_shift
      always_comb begin
        pipe_d = {pipe_q[r-1:0], push_vec[r]};
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign row_val[r] = pipe_q[r];
  end

  assign row1_val  = row_val[0];
  assign row2_val  = row_val[1];
  assign row3_val  = row_val[2];
  assign row4_val  = row_val[3];
  assign weights   = weights_q;
  assign vec_count = vec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_feeder
//  Purpose  : Directed self-checking bench for systolic_feeder. A timestamp
//             model derives the expected state phase and skewed row values
//             from the accept cycles of weight tiles and activation vectors.
//             A few literal expectations pin the model to hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  localparam int W = 8;
  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_STREAM = 2;
  localparam int P_DRAIN  = 3;
  localparam int P_DONE   = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    w_valid;
  logic                    w_ready;
  logic [3:0][3:0][W-1:0]  w_data;
  logic [3:0][3:0][W-1:0]  weights;
  logic                    load;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0][W-1:0]       in_vec;
  logic                    in_last;
  logic [W-1:0]            row1_val, row2_val, row3_val, row4_val;
  logic                    busy;
  logic                    done;
  logic [15:0]             vec_count;

  systolic_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .weights   (weights),
    .load      (load),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_last   (in_last),
    .row1_val  (row1_val),
    .row2_val  (row2_val),
    .row3_val  (row3_val),
    .row4_val  (row4_val),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0][W-1:0] mkvec(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    logic [3:0][W-1:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  function automatic logic [3:0][3:0][W-1:0] mktile(input int base);
    logic [3:0][3:0][W-1:0] t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        t[i][j] = W'(base + 4 * i + j);
    return t;
  endfunction

  // ---------------- model: timestamps of accepts ----------------
  int                      m_tw  = -1000;   // cycle of last weight accept
  int                      m_tl  = -1000;   // cycle of last in_last accept
  int                      m_cnt = 0;
  logic [3:0][3:0][W-1:0]  m_w   = '0;
  bit                      acc_valid [512];
  logic [3:0][W-1:0]       acc_data  [512];

  function automatic int phase_of(input int c);
    int d, e;
    if (m_tw < 0) return P_IDLE;
    d = c - m_tw;
    if (d == 1) return P_LOAD;
    if (m_tl < m_tw) return P_STREAM;
    e = c - m_tl;
    if (e <= 0) return P_STREAM;
    if (e <= 3) return P_DRAIN;
    if (e == 4) return P_DONE;
    return P_IDLE;
  endfunction

  function automatic logic [W-1:0] exp_row(input int c, input int r);
    int idx;
    idx = c - 1 - r;
    if (idx >= 0 && acc_valid[idx]) return acc_data[idx][r];
    return '0;
  endfunction

  always @(negedge clk) begin
    int c;
    int ph;
    c = cyc;
    if (reset) begin
      m_tw  = -1000;
      m_tl  = -1000;
      m_cnt = 0;
      m_w   = '0;
      for (int i = 0; i < 512; i++) acc_valid[i] = 1'b0;
    end
    ph = phase_of(c);

    chk("w_ready",   128'(w_ready),  128'(ph == P_IDLE));
    chk("in_ready",  128'(in_ready), 128'(ph == P_STREAM));
    chk("load",      128'(load),     128'(ph == P_LOAD));
    chk("done",      128'(done),     128'(ph == P_DONE));
    chk("busy",      128'(busy),     128'(ph != P_IDLE));
    chk("vec_count", 128'(vec_count), 128'(m_cnt));
    chk("weights",   128'(weights),  128'(m_w));
    chk("row1",      128'(row1_val), 128'(exp_row(c, 0)));
    chk("row2",      128'(row2_val), 128'(exp_row(c, 1)));
    chk("row3",      128'(row3_val), 128'(exp_row(c, 2)));
    chk("row4",      128'(row4_val), 128'(exp_row(c, 3)));

    // hand-computed anchors
    case (c)
      2:  begin chk("lit_rst_w_ready", 128'(w_ready), 128'(1)); chk("lit_rst_busy", 128'(busy), 128'(0)); end
      11: begin chk("lit_load", 128'(load), 128'(1)); chk("lit_w23", 128'(weights[2][3]), 128'(11)); end
      12: begin chk("lit_in_ready", 128'(in_ready), 128'(1)); chk("lit_load_off", 128'(load), 128'(0)); end
      13: chk("lit_row1_v0", 128'(row1_val), 128'(1));
      15: chk("lit_row2_v1", 128'(row2_val), 128'(6));
      16: chk("lit_row4_v0", 128'(row4_val), 128'(4));
      17: chk("lit_row3_v2", 128'(row3_val), 128'(11));
      18: begin
        chk("lit_row4_v2", 128'(row4_val), 128'(12));
        chk("lit_done", 128'(done), 128'(1));
        chk("lit_count3", 128'(vec_count), 128'(3));
      end
      19: chk("lit_idle", 128'(w_ready), 128'(1));
      25: chk("lit_bubble_row1", 128'(row1_val), 128'(0));
      26: chk("lit_shift_row1", 128'(row1_val), 128'(25));
      29: begin chk("lit_done_b", 128'(done), 128'(1)); chk("lit_count2", 128'(vec_count), 128'(2)); end
      35: chk("lit_single_row2", 128'(row2_val), 128'(8'h80));
      37: begin chk("lit_single_row4", 128'(row4_val), 128'(8'h7F)); chk("lit_single_done", 128'(done), 128'(1)); end
      44: chk("lit_bp_w_ready", 128'(w_ready), 128'(0));
      48: begin chk("lit_bp_load", 128'(load), 128'(1)); chk("lit_bp_w00", 128'(weights[0][0]), 128'(8'h30)); end
      51: begin
        chk("lit_rst_row1", 128'(row1_val), 128'(0));
        chk("lit_rst_count", 128'(vec_count), 128'(0));
        chk("lit_rst_busy_mid", 128'(busy), 128'(0));
      end
      53: chk("lit_release_w_ready", 128'(w_ready), 128'(1));
      default: ;
    endcase

    // record what the feeder must have accepted on the coming edge
    if (!reset) begin
      if (ph == P_IDLE && w_valid) begin
        m_tw  = c;
        m_w   = w_data;
        m_cnt = 0;
      end
      if (ph == P_STREAM && in_valid) begin
        acc_valid[c] = 1'b1;
        acc_data[c]  = in_vec;
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (in_last) m_tl = c;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    w_valid  = 1'b0;
    w_data   = '0;
    in_valid = 1'b0;
    in_vec   = '0;
    in_last  = 1'b0;

    at(4);  reset = 1'b0;

    // tile A: weight load then three back-to-back vectors
    at(10); w_valid = 1'b1; w_data = mktile(0);
    at(11); w_valid = 1'b0; w_data = mktile(8'hE0);
    at(12); in_valid = 1'b1; in_vec = mkvec(1, 2, 3, 4);
    at(13); in_vec = mkvec(5, 6, 7, 8);
    at(14); in_vec = mkvec(9, 10, 11, 12); in_last = 1'b1;
    at(15); in_vec = mkvec(99, 98, 97, 96); in_last = 1'b0;   // offered in DRAIN
    at(17); in_valid = 1'b0;

    // tile B: bubble between two vectors, stray in_last during the bubble
    at(21); w_valid = 1'b1; w_data = mktile(8'hA0);
    at(22); w_valid = 1'b0;
    at(23); in_valid = 1'b1; in_vec = mkvec(21, 22, 23, 24);
    at(24); in_valid = 1'b0; in_last = 1'b1;
    at(25); in_valid = 1'b1; in_vec = mkvec(25, 26, 27, 28);
    at(26); in_valid = 1'b0; in_last = 1'b0;

    // tile C: single vector with in_last
    at(31); w_valid = 1'b1; w_data = mktile(8'h40);
    at(32); w_valid = 1'b0;
    at(33); in_valid = 1'b1; in_last = 1'b1; in_vec = mkvec(8'hFF, 8'h80, 8'h01, 8'h7F);
    at(34); in_valid = 1'b0; in_last = 1'b0;

    // tile D with the next tile E held on w_valid throughout
    at(39); w_valid = 1'b1; w_data = mktile(8'h10);
    at(40); w_data = mktile(8'h30);
    at(41); in_valid = 1'b1; in_vec = mkvec(31, 32, 33, 34);
    at(42); in_vec = mkvec(35, 36, 37, 38); in_last = 1'b1;
    at(43); in_valid = 1'b0; in_last = 1'b0;
    at(48); w_valid = 1'b0;

    // tile E: two vectors, then reset mid-stream
    at(49); in_valid = 1'b1; in_vec = mkvec(41, 42, 43, 44);
    at(50); in_vec = mkvec(45, 46, 47, 48);
    at(51); reset = 1'b1; in_valid = 1'b0;
    at(53); reset = 1'b0;

    at(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
# systolic_feeder

Input-side sequencer that sits directly upstream of the 4x4 weight-stationary systolic array. It captures a 4x4 weight tile, issues a single-cycle weight-load pulse, and accepts a stream of 4-element activation vectors over a valid/ready handshake. It emits those vectors diagonally skewed onto the array's four west-edge row inputs, so that row r is delayed r cycles relative to row 0. After the last vector it drains zeros until the skew pipeline is empty.

## Interface
Parameters:
- WIDTH, 8, element width of weights and activations (8 = int8 array, 16 = bf16 array)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- w_valid  in  1  weight tile offered
- w_ready  out  1  feeder can accept a weight tile
- w_data  in  [WIDTH-1:0] x [3:0][3:0]  weight tile, [row][col]
- weights  out  [WIDTH-1:0] x [3:0][3:0]  registered weight tile driven to the array
- load  out  1  weight-load strobe to the array
- in_valid  in  1  activation vector offered
- in_ready  out  1  feeder accepts the vector this cycle
- in_vec  in  [WIDTH-1:0] x [3:0]  activation vector; element r goes to array row r
- in_last  in  1  marks the final vector of the tile stream
- row1_val, row2_val, row3_val, row4_val  out  WIDTH  skewed west-edge inputs to the array
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the drain is complete
- vec_count  out  16  vectors accepted since the last weight load

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- **IDLE**
  - w_ready=1, in_ready=0.
  - On w_valid&&w_ready: register w_data into weights, clear vec_count, go to LOAD.
- **LOAD**
  - load=1 for exactly this one cycle.
  - weights stays stable from now until the next accepted tile.
  - Next state: STREAM.
- **STREAM**
  - in_ready=1.
  - On in_valid&&in_ready: push in_vec into the skew pipeline and increment vec_count. vec_count saturates at 0xFFFF.
  - Cycle with no accepted vector: push all-zero elements. Zero activations leave the array sums unchanged.
  - Accepted vector with in_last=1: go to DRAIN with drain counter = 3.
- **DRAIN**
  - in_ready=0.
  - Push zeros each cycle and decrement the counter.
  - When the counter reaches 0 after 3 cycles, go to DONE.
- **DONE**
  - done=1 for one cycle.
  - Next state: IDLE.
- **Skew pipeline**
  - Row r (0..3) output = element r of the vector pushed at cycle t, appearing at row(r+1)_val at cycle t+1+r.
  - Stage 0 is one register per row. Rows 1..3 add r further registers.
  - All skew registers shift every cycle in every state. In IDLE and LOAD they shift in zeros.
- w_ready is 0 outside IDLE. A weight tile offered mid-stream is held off by the source, not dropped.
- Data is passed bit-exact. The feeder does no arithmetic on weights or activations.

## Timing
- **Reset values:** state=IDLE; weights all 0; load=0; w_ready=1; in_ready=0; row1..4_val=0; busy=0; done=0; vec_count=0; drain counter=0; all skew registers 0.
- **Reset mid-operation** (any state): immediate return to the reset values above. In-flight skew data is discarded. No done pulse.
- **Weight-accept-to-load latency:** 1 cycle. Handshake at cycle t gives load=1 at t+1. First in_ready=1 at t+2.
- **Activation latency:** row1 = 1 cycle, row2 = 2, row3 = 3, row4 = 4 after the handshake cycle.
- **in_last latency:** in_last accepted at cycle t means DRAIN at t+1..t+3, done=1 at t+4, IDLE (w_ready=1) at t+5. Row4 shows the last element at t+4.
- **in_valid and in_last with zero prior vectors:** valid. The single vector is streamed and drained normally.
- **in_last while in_valid=0:** ignored. in_last is only sampled on a handshake.
- **Back-to-back tiles:** a new weight handshake is possible at t+5. There is no overlap with drain.

## Test plan
- **Reset/idle:** assert reset mid-STREAM after 2 vectors -> all outputs zero on the same cycle; w_ready=1 after release; no done pulse.
- **Weight load:** w_data[i][j]=4*i+j with w_valid at cycle 10 -> load=1 only at cycle 11; weights matches w_data from cycle 11; in_ready=1 at cycle 12.
- **Skew check:** stream vectors v0={1,2,3,4}, v1={5,6,7,8}, v2={9,10,11,12} at cycles 12,13,14 with in_last on v2 -> required rows:
  - row1_val: 1,5,9 at cycles 13,14,15
  - row2_val: 2,6,10 at cycles 14,15,16
  - row3_val: 3,7,11 at cycles 15,16,17
  - row4_val: 4,8,12 at cycles 16,17,18
  - all other row cycles 0
  - done=1 at 18; vec_count=3.
- **Bubbles:** in_valid low at cycle 13 between v0 and v1 -> zeros appear in each row one slot after v0's element; v1 is shifted one cycle later; vec_count=2 at the end.
- **Single-vector tile:** one vector {0xFF,0x80,0x01,0x7F} with in_last -> values appear on rows 1..4 at +1..+4; done at +4.
- **Back-pressure on weights:** w_valid held high during STREAM -> w_ready stays 0; the tile is accepted in the IDLE cycle following done, followed by a second load pulse.
